// File: rtl/mem_arbiter_n.sv
// Multi-client SRAM bank arbiter with a rotating frame-buffer role table.
// Clients reach banks through their current role; read data is routed back by client tag.
module mem_arbiter_n #(
    parameter int NUM_CLIENTS = 4,
    parameter int NUM_BANKS   = 2,
    parameter int ADDR_W      = 19,
    parameter int DATA_W      = 36,
    parameter int BUF_W       = 17,
    parameter int READ_LAT    = 2,
    parameter int ARB_MODE    = 0
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          frame_flag,
    input  logic [NUM_CLIENTS-1:0]        cl_req,
    input  logic [NUM_CLIENTS-1:0]        cl_wr,
    input  logic [NUM_CLIENTS*BUF_W-1:0]  cl_addr,
    input  logic [NUM_CLIENTS*DATA_W-1:0] cl_wdata,
    output logic [NUM_CLIENTS-1:0]        cl_grant,
    output logic [NUM_CLIENTS-1:0]        cl_rvalid,
    output logic [NUM_CLIENTS*DATA_W-1:0] cl_rdata,
    output logic [NUM_BANKS*ADDR_W-1:0]   mem_addr,
    output logic [NUM_BANKS*DATA_W-1:0]   mem_wdata,
    output logic [NUM_BANKS-1:0]          mem_wr,
    input  logic [NUM_BANKS*DATA_W-1:0]   mem_rdata
);

    localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam int CID_W  = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
    localparam int LOC_W  = CID_W;
    localparam int FULL_W = LOC_W + BUF_W;

    typedef struct packed {
        logic [BANK_W-1:0] bank;
        logic [LOC_W-1:0]  loc;
    } role_t;

    typedef struct packed {
        logic             valid;
        logic [CID_W-1:0] cid;
    } tag_t;

    role_t                  roleTable_q [NUM_CLIENTS];
    role_t                  roleTable_d [NUM_CLIENTS];
    logic [CID_W-1:0]       rrPtr_q     [NUM_BANKS];
    logic [CID_W-1:0]       rrPtr_d     [NUM_BANKS];
    tag_t                   tagPipe_q   [NUM_BANKS][READ_LAT];
    logic [NUM_CLIENTS-1:0] rvalid_q;
    logic [NUM_CLIENTS-1:0] rvalid_d;
    logic [DATA_W-1:0]      rdata_q     [NUM_CLIENTS];
    logic [DATA_W-1:0]      rdata_d     [NUM_CLIENTS];

    logic [ADDR_W-1:0]      clientAddr  [NUM_CLIENTS];
    logic [DATA_W-1:0]      clientWdata [NUM_CLIENTS];
    logic                   grantValid  [NUM_BANKS];
    logic [CID_W-1:0]       grantId     [NUM_BANKS];
    tag_t                   pushTag     [NUM_BANKS];

    // The buffer base is loc*BUF_WORDS, so the bank address is simply {loc, offset}.
    for (genvar i = 0; i < NUM_CLIENTS; i++) begin : gClient
        logic [FULL_W-1:0] fullAddr;
        assign fullAddr = {roleTable_q[i].loc, cl_addr[i*BUF_W +: BUF_W]};
        if (FULL_W >= ADDR_W) begin : gTrunc
            assign clientAddr[i] = fullAddr[ADDR_W-1:0];
        end else begin : gExt
            assign clientAddr[i] = {{(ADDR_W-FULL_W){1'b0}}, fullAddr};
        end
        assign clientWdata[i]                 = cl_wdata[i*DATA_W +: DATA_W];
        assign cl_rdata[i*DATA_W +: DATA_W]   = rdata_q[i];
    end

    // Per-bank search; round-robin starts at the bank pointer and wraps.
    always_comb begin
        int               idx;
        logic [CID_W-1:0] cand;
        idx  = 0;
        cand = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            grantValid[b] = 1'b0;
            grantId[b]    = '0;
            for (int k = 0; k < NUM_CLIENTS; k++) begin
                idx = (ARB_MODE == 1) ? int'(rrPtr_q[b]) + k : k;
                if (idx >= NUM_CLIENTS) begin
                    idx = idx - NUM_CLIENTS;
                end
                cand = CID_W'(idx);
                if (!grantValid[b] && cl_req[cand] &&
                    roleTable_q[cand].bank == BANK_W'(b)) begin
                    grantValid[b] = 1'b1;
                    grantId[b]    = cand;
                end
            end
        end
    end

    always_comb begin
        cl_grant  = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wr    = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            rrPtr_d[b] = rrPtr_q[b];
            pushTag[b] = '0;
            if (grantValid[b]) begin
                cl_grant[grantId[b]]           = 1'b1;
                mem_addr[b*ADDR_W +: ADDR_W]   = clientAddr[grantId[b]];
                mem_wdata[b*DATA_W +: DATA_W]  = clientWdata[grantId[b]];
                mem_wr[b]                      = cl_wr[grantId[b]];
                pushTag[b].valid               = !cl_wr[grantId[b]];
                pushTag[b].cid                 = grantId[b];
                rrPtr_d[b] = (grantId[b] == CID_W'(NUM_CLIENTS - 1)) ?
                             '0 : grantId[b] + CID_W'(1);
            end
        end
    end

    // Tags carry the issuing client, so role rotation cannot misroute in-flight data.
    always_comb begin
        rvalid_d = '0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            rdata_d[i] = rdata_q[i];
        end
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (tagPipe_q[b][READ_LAT-1].valid) begin
                rvalid_d[tagPipe_q[b][READ_LAT-1].cid] = 1'b1;
                rdata_d[tagPipe_q[b][READ_LAT-1].cid]  = mem_rdata[b*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            roleTable_d[i] = frame_flag ? roleTable_q[(i + 1) % NUM_CLIENTS] : roleTable_q[i];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_CLIENTS; i++) begin
                roleTable_q[i].bank <= BANK_W'(i % NUM_BANKS);
                roleTable_q[i].loc  <= LOC_W'(i / NUM_BANKS);
                rdata_q[i]          <= '0;
            end
            for (int b = 0; b < NUM_BANKS; b++) begin
                rrPtr_q[b] <= '0;
                for (int k = 0; k < READ_LAT; k++) begin
                    tagPipe_q[b][k] <= '0;
                end
            end
            rvalid_q <= '0;
        end else begin
            for (int i = 0; i < NUM_CLIENTS; i++) begin
                roleTable_q[i] <= roleTable_d[i];
                rdata_q[i]     <= rdata_d[i];
            end
            for (int b = 0; b < NUM_BANKS; b++) begin
                rrPtr_q[b]      <= rrPtr_d[b];
                tagPipe_q[b][0] <= pushTag[b];
                for (int k = 1; k < READ_LAT; k++) begin
                    tagPipe_q[b][k] <= tagPipe_q[b][k-1];
                end
            end
            rvalid_q <= rvalid_d;
        end
    end

    assign cl_rvalid = rvalid_q;

endmodule

// File: tb/tb_mem_arbiter_n.sv
// Bench for mem_arbiter_n: fixed-priority and round-robin instances side by side,
// compared every cycle against a rotation-count model, plus hand-computed scenarios.
module tb_mem_arbiter_n;

    localparam int NC = 4;
    localparam int NB = 2;
    localparam int AW = 19;
    localparam int DW = 36;
    localparam int BW = 17;
    localparam int RL = 2;

    localparam logic [DW-1:0] RD_BANK0 = 36'h123456789;
    localparam logic [DW-1:0] RD_BANK1 = 36'hFEDCBA987;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic frame_flag = 1'b0;
    logic [NC-1:0]    cl_req = '0;
    logic [NC-1:0]    cl_wr = '0;
    logic [NC*BW-1:0] cl_addr = '0;
    logic [NC*DW-1:0] cl_wdata = '0;
    logic [NB*DW-1:0] mem_rdata = '0;

    logic [NC-1:0]    grantA, grantB, rvalidA, rvalidB;
    logic [NC*DW-1:0] rdataA, rdataB;
    logic [NB*AW-1:0] addrA, addrB;
    logic [NB*DW-1:0] wdataA, wdataB;
    logic [NB-1:0]    wrA, wrB;

    int total = 0;
    int bad = 0;

    mem_arbiter_n #(.NUM_CLIENTS(NC), .NUM_BANKS(NB), .ADDR_W(AW), .DATA_W(DW),
                    .BUF_W(BW), .READ_LAT(RL), .ARB_MODE(0)) dutFixed (
        .clock(clock), .reset_n(reset_n), .frame_flag(frame_flag),
        .cl_req(cl_req), .cl_wr(cl_wr), .cl_addr(cl_addr), .cl_wdata(cl_wdata),
        .cl_grant(grantA), .cl_rvalid(rvalidA), .cl_rdata(rdataA),
        .mem_addr(addrA), .mem_wdata(wdataA), .mem_wr(wrA), .mem_rdata(mem_rdata));

    mem_arbiter_n #(.NUM_CLIENTS(NC), .NUM_BANKS(NB), .ADDR_W(AW), .DATA_W(DW),
                    .BUF_W(BW), .READ_LAT(RL), .ARB_MODE(1)) dutRr (
        .clock(clock), .reset_n(reset_n), .frame_flag(frame_flag),
        .cl_req(cl_req), .cl_wr(cl_wr), .cl_addr(cl_addr), .cl_wdata(cl_wdata),
        .cl_grant(grantB), .cl_rvalid(rvalidB), .cl_rdata(rdataB),
        .mem_addr(addrB), .mem_wdata(wdataB), .mem_wr(wrB), .mem_rdata(mem_rdata));

    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Model: after r frame pulses, client c holds the reset role of (c+r) mod NC.
    typedef struct {
        int mode;
        int due;
        int cl;
        int bk;
    } pend_t;

    int              rot = 0;
    int              ptr [2][NB];
    logic [DW-1:0]   expRdata [2][NC];
    pend_t           pend [$];
    logic [NB*DW-1:0] histRd [16];
    int              cyc = 0;

    function automatic int bankOf(input int c);
        return ((c + rot) % NC) % NB;
    endfunction

    function automatic logic [AW-1:0] addrOf(input int c);
        longint full;
        full = longint'((c + rot) % NC / NB) * (longint'(1) << BW) + longint'(cl_addr[c*BW +: BW]);
        return AW'(full & ((longint'(1) << AW) - 1));
    endfunction

    task automatic modelReset();
        rot = 0;
        for (int m = 0; m < 2; m++) begin
            for (int b = 0; b < NB; b++) ptr[m][b] = 0;
            for (int c = 0; c < NC; c++) expRdata[m][c] = '0;
        end
        pend.delete();
    endtask

    always @(negedge clock) begin : compare
        int               bestKey, key;
        int               winner [NB];
        logic [NC-1:0]    eGrant, eRvalid, dGrant, dRvalid;
        logic [NB-1:0]    eWr, dWr;
        logic [AW-1:0]    eAddr [NB];
        logic [DW-1:0]    eWd [NB];
        logic [NB*AW-1:0] dAddr;
        logic [NB*DW-1:0] dWd;
        logic [NC*DW-1:0] dRd;
        if (!reset_n) modelReset();
        cyc++;
        histRd[cyc % 16] = mem_rdata;
        for (int m = 0; m < 2; m++) begin
            dGrant  = (m == 0) ? grantA  : grantB;
            dRvalid = (m == 0) ? rvalidA : rvalidB;
            dRd     = (m == 0) ? rdataA  : rdataB;
            dAddr   = (m == 0) ? addrA   : addrB;
            dWd     = (m == 0) ? wdataA  : wdataB;
            dWr     = (m == 0) ? wrA     : wrB;
            eGrant = '0;
            eWr    = '0;
            for (int b = 0; b < NB; b++) begin
                winner[b] = -1;
                eAddr[b]  = '0;
                eWd[b]    = '0;
                bestKey   = NC;
                for (int c = 0; c < NC; c++) begin
                    if (cl_req[c] && bankOf(c) == b) begin
                        key = (m == 0) ? c : (c - ptr[m][b] + NC) % NC;
                        if (key < bestKey) begin
                            bestKey   = key;
                            winner[b] = c;
                        end
                    end
                end
                if (winner[b] >= 0) begin
                    eGrant[winner[b]] = 1'b1;
                    eAddr[b] = addrOf(winner[b]);
                    eWd[b]   = cl_wdata[winner[b]*DW +: DW];
                    eWr[b]   = cl_wr[winner[b]];
                end
            end
            eRvalid = '0;
            for (int k = pend.size() - 1; k >= 0; k--) begin
                if (pend[k].mode == m && pend[k].due == cyc) begin
                    eRvalid[pend[k].cl] = 1'b1;
                    expRdata[m][pend[k].cl] = histRd[(cyc - 1) % 16][pend[k].bk*DW +: DW];
                    pend.delete(k);
                end
            end
            checkOutput($sformatf("m%0d c%0d grant", m, cyc), 64'(dGrant), 64'(eGrant));
            checkOutput($sformatf("m%0d c%0d mem_wr", m, cyc), 64'(dWr), 64'(eWr));
            checkOutput($sformatf("m%0d c%0d rvalid", m, cyc), 64'(dRvalid), 64'(eRvalid));
            for (int b = 0; b < NB; b++) begin
                checkOutput($sformatf("m%0d c%0d addr b%0d", m, cyc, b), 64'(dAddr[b*AW +: AW]), 64'(eAddr[b]));
                checkOutput($sformatf("m%0d c%0d wdata b%0d", m, cyc, b), 64'(dWd[b*DW +: DW]), 64'(eWd[b]));
            end
            for (int c = 0; c < NC; c++) begin
                checkOutput($sformatf("m%0d c%0d rdata cl%0d", m, cyc, c), 64'(dRd[c*DW +: DW]), 64'(expRdata[m][c]));
            end
            if (reset_n) begin
                for (int b = 0; b < NB; b++) begin
                    if (winner[b] >= 0) begin
                        if (!cl_wr[winner[b]]) pend.push_back('{m, cyc + RL + 1, winner[b], b});
                        ptr[m][b] = (winner[b] + 1) % NC;
                    end
                end
            end
        end
        if (reset_n && frame_flag) rot = (rot + 1) % NC;
    end

    task automatic stepCycle();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic [NC-1:0] req, input logic [NC-1:0] wr,
                                 input int off0, input int off1, input int off2, input int off3,
                                 input logic flag);
        stepCycle();
        cl_req     = req;
        cl_wr      = wr;
        cl_addr    = {BW'(off3), BW'(off2), BW'(off1), BW'(off0)};
        frame_flag = flag;
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus('0, '0, 0, 0, 0, 0, 1'b0);
    endtask

    initial begin
        mem_rdata = {RD_BANK1, RD_BANK0};
        for (int c = 0; c < NC; c++) cl_wdata[c*DW +: DW] = DW'(36'h0A5A50000 + c);
        reset_n = 1'b0;
        repeat (3) stepCycle();
        stepCycle();
        reset_n = 1'b1;
        @(negedge clock);
        checkOutput("reset grant", 64'(grantA), 64'h0);
        checkOutput("reset mem_addr", 64'(addrA), 64'h0);
        checkOutput("reset rvalid", 64'(rvalidA | rvalidB), 64'h0);
        checkOutput("reset rdata", 64'(|rdataA), 64'h0);

        // Clients 0 and 2 share bank 0 in the reset table.
        for (int k = 0; k < 4; k++) begin
            applyStimulus(4'b0101, 4'b0000, 0, 0, 0, 0, 1'b0);
            @(negedge clock);
            checkOutput($sformatf("fixed contention %0d", k), 64'(grantA), 64'h1);
            checkOutput($sformatf("rr contention %0d", k), 64'(grantB), (k % 2 == 0) ? 64'h1 : 64'h4);
        end
        idle(4);

        applyStimulus(4'b0001, 4'b0000, 5, 0, 0, 0, 1'b0);
        @(negedge clock);
        checkOutput("read0 grant", 64'(grantA), 64'h1);
        checkOutput("read0 bank0 addr", 64'(addrA[0 +: AW]), 64'd5);
        checkOutput("read0 mem_wr", 64'(wrA), 64'h0);
        idle(3);
        @(negedge clock);
        checkOutput("read0 rvalid", 64'(rvalidA), 64'h1);
        checkOutput("read0 rdata", 64'(rdataA[0 +: DW]), 64'(RD_BANK0));

        applyStimulus(4'b0011, 4'b0011, 9, 7, 0, 0, 1'b0);
        @(negedge clock);
        checkOutput("dual write grant", 64'(grantA), 64'h3);
        checkOutput("dual write bank1 addr", 64'(addrA[AW +: AW]), 64'd7);
        checkOutput("dual write bank0 addr", 64'(addrA[0 +: AW]), 64'd9);
        checkOutput("dual write mem_wr", 64'(wrA), 64'h3);
        checkOutput("dual write bank1 wdata", 64'(wdataA[DW +: DW]), 64'h0A5A50001);

        applyStimulus('0, '0, 0, 0, 0, 0, 1'b1);
        applyStimulus(4'b0001, 4'b0000, 3, 0, 0, 0, 1'b0);
        @(negedge clock);
        checkOutput("rotated client0 bank1 addr", 64'(addrA[AW +: AW]), 64'd3);
        checkOutput("rotated bank0 idle", 64'(addrA[0 +: AW]), 64'd0);
        checkOutput("rotated grant", 64'(grantA), 64'h1);
        repeat (3) applyStimulus('0, '0, 0, 0, 0, 0, 1'b1);
        applyStimulus(4'b0011, 4'b0000, 3, 4, 0, 0, 1'b0);
        @(negedge clock);
        checkOutput("four pulses bank0 addr", 64'(addrA[0 +: AW]), 64'd3);
        checkOutput("four pulses bank1 addr", 64'(addrA[AW +: AW]), 64'd4);
        applyStimulus(4'b0100, 4'b0000, 0, 0, 4, 0, 1'b0);
        @(negedge clock);
        checkOutput("client2 loc1 addr", 64'(addrA[0 +: AW]), 64'h20004);
        idle(4);

        applyStimulus(4'b0010, 4'b0000, 0, 6, 0, 0, 1'b0);
        @(negedge clock);
        checkOutput("flight read grant", 64'(grantA), 64'h2);
        applyStimulus('0, '0, 0, 0, 0, 0, 1'b1);
        idle(2);
        @(negedge clock);
        checkOutput("flight rvalid", 64'(rvalidA), 64'h2);
        checkOutput("flight rdata", 64'(rdataA[DW +: DW]), 64'(RD_BANK1));
        idle(4);

        applyStimulus(4'b0010, 4'b0000, 0, 6, 0, 0, 1'b0);
        @(negedge clock);
        checkOutput("abort read grant", 64'(grantA), 64'h2);
        stepCycle();
        cl_req  = '0;
        reset_n = 1'b0;
        stepCycle();
        stepCycle();
        reset_n = 1'b1;
        @(negedge clock);
        checkOutput("abort rvalid", 64'(rvalidA), 64'h0);
        checkOutput("abort rdata", 64'(rdataA[DW +: DW]), 64'h0);
        stepCycle();
        @(negedge clock);
        checkOutput("abort rvalid later", 64'(rvalidA), 64'h0);

        for (int n = 0; n < 3000; n++) begin
            stepCycle();
            cl_req     = NC'($urandom());
            cl_wr      = NC'($urandom()) & NC'($urandom());
            cl_addr    = (NC*BW)'({$urandom(), $urandom(), $urandom()});
            cl_wdata   = (NC*DW)'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
            mem_rdata  = (NB*DW)'({$urandom(), $urandom(), $urandom()});
            frame_flag = ($urandom_range(0, 7) == 0);
            reset_n    = ($urandom_range(0, 249) != 0);
        end
        stepCycle();
        reset_n = 1'b1;
        idle(8);
        @(negedge clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
